traffic_light_driver: RTL and testbench

Output stage directly downstream of the traffic-light phase counter. It samples the counter's `state`/`count` pair on every `clock_div` edge and drives the three lamp outputs and two active-low seven-segment digits showing the remaining count. It also runs an independent reference model of the phase sequence: any deviation latches a sticky fault, which forces a flashing-yellow safe mode and a "--" display. It counts completed green→yellow→red cycles for diagnostics.

---
 rtl/traffic_light_driver.sv | 138 +++++++++++++
 tb/tb_traffic_light_driver.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_driver.sv
// Lamp/seven-segment output stage with an independent phase-sequence checker.
// One-tick sampling lag; a sequence error latches a flashing-yellow safe mode.
module traffic_light_driver #(
  parameter logic [3:0] GREEN_LOAD  = 4'd15,
  parameter logic [3:0] YELLOW_LOAD = 4'd5,
  parameter logic [3:0] RED_LOAD    = 4'd10
) (
  input  logic       clock_div,
  input  logic       reset,
  input  logic [1:0] state_in,
  input  logic [3:0] count_in,
  output logic       red,
  output logic       yellow,
  output logic       green,
  output logic [6:0] seg_tens,
  output logic [6:0] seg_ones,
  output logic       fault,
  output logic [7:0] cycles
);

  typedef enum logic [1:0] {
    ST_GREEN   = 2'd0,
    ST_YELLOW  = 2'd1,
    ST_RED     = 2'd2,
    ST_ILLEGAL = 2'd3
  } phase_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ONE   = 7'h79;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  phase_e     es_q, es_d;
  logic [3:0] ec_q, ec_d;
  logic       fault_q, fault_d;
  logic       blink_q, blink_d;
  logic [7:0] cycles_q, cycles_d;
  logic       red_q, red_d, yellow_q, yellow_d, green_q, green_d;
  logic [6:0] tens_q, tens_d, ones_q, ones_d;
  logic       match;

  function automatic logic [6:0] digit(input logic [3:0] d);
    case (d)
      4'd0:    digit = 7'h40;
      4'd1:    digit = 7'h79;
      4'd2:    digit = 7'h24;
      4'd3:    digit = 7'h30;
      4'd4:    digit = 7'h19;
      4'd5:    digit = 7'h12;
      4'd6:    digit = 7'h02;
      4'd7:    digit = 7'h78;
      4'd8:    digit = 7'h00;
      4'd9:    digit = 7'h10;
      default: digit = SEG_DASH;
    endcase
  endfunction

  assign match = (phase_e'(state_in) == es_q) && (count_in == ec_q);

  always_comb begin
    es_d     = es_q;
    ec_d     = ec_q;
    fault_d  = fault_q;
    blink_d  = blink_q;
    cycles_d = cycles_q;
    red_d    = red_q;
    yellow_d = yellow_q;
    green_d  = green_q;
    tens_d   = tens_q;
    ones_d   = ones_q;
    if (fault_q) begin
      // Safe mode: everything frozen except the yellow flasher.
      blink_d  = ~blink_q;
      yellow_d = ~blink_q;
    end else if (!match) begin
      fault_d  = 1'b1;
      blink_d  = 1'b1;
      yellow_d = 1'b1;
      red_d    = 1'b0;
      green_d  = 1'b0;
      tens_d   = SEG_DASH;
      ones_d   = SEG_DASH;
    end else begin
      red_d    = (phase_e'(state_in) == ST_RED);
      yellow_d = (phase_e'(state_in) == ST_YELLOW);
      green_d  = (phase_e'(state_in) == ST_GREEN);
      tens_d   = (count_in >= 4'd10) ? SEG_ONE : SEG_BLANK;
      ones_d   = digit((count_in >= 4'd10) ? count_in - 4'd10 : count_in);
      if (ec_q != 4'd0) begin
        ec_d = ec_q - 4'd1;
      end else begin
        case (es_q)
          ST_GREEN:  begin es_d = ST_YELLOW; ec_d = YELLOW_LOAD; end
          ST_YELLOW: begin es_d = ST_RED;    ec_d = RED_LOAD;    end
          default: begin
            es_d = ST_GREEN;
            ec_d = GREEN_LOAD;
            if (cycles_q != 8'hFF) cycles_d = cycles_q + 8'd1;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clock_div or negedge reset) begin
    if (!reset) begin
      es_q     <= ST_GREEN;
      ec_q     <= GREEN_LOAD;
      fault_q  <= 1'b0;
      blink_q  <= 1'b0;
      cycles_q <= 8'd0;
      red_q    <= 1'b1;
      yellow_q <= 1'b0;
      green_q  <= 1'b0;
      tens_q   <= SEG_BLANK;
      ones_q   <= SEG_BLANK;
    end else begin
      es_q     <= es_d;
      ec_q     <= ec_d;
      fault_q  <= fault_d;
      blink_q  <= blink_d;
      cycles_q <= cycles_d;
      red_q    <= red_d;
      yellow_q <= yellow_d;
      green_q  <= green_d;
      tens_q   <= tens_d;
      ones_q   <= ones_d;
    end
  end

  assign red      = red_q;
  assign yellow   = yellow_q;
  assign green    = green_q;
  assign seg_tens = tens_q;
  assign seg_ones = ones_q;
  assign fault    = fault_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_light_driver.sv
// Directed bench for traffic_light_driver: sequence display, digits, faults,
// asynchronous reset and cycle-counter saturation.
module tb_traffic_light_driver;

  logic       clock_div;
  logic       reset;
  logic [1:0] state_in;
  logic [3:0] count_in;
  logic       red, yellow, green, fault;
  logic [6:0] seg_tens, seg_ones;
  logic [7:0] cycles;

  int tests_run    = 0;
  int tests_failed = 0;

  traffic_light_driver dut (
    .clock_div (clock_div),
    .reset     (reset),
    .state_in  (state_in),
    .count_in  (count_in),
    .red       (red),
    .yellow    (yellow),
    .green     (green),
    .seg_tens  (seg_tens),
    .seg_ones  (seg_ones),
    .fault     (fault),
    .cycles    (cycles)
  );

  initial clock_div = 1'b0;
  always #5 clock_div = ~clock_div;

  function automatic logic [6:0] exp_digit(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Upstream counter value at tick k after reset release (33-tick period).
  task automatic phase_at(input int k, output logic [1:0] s, output logic [3:0] c);
    int m;
    m = k % 33;
    if (m < 16)      begin s = 2'd0; c = 4'(15 - m); end
    else if (m < 22) begin s = 2'd1; c = 4'(21 - m); end
    else             begin s = 2'd2; c = 4'(32 - m); end
  endtask

  // Present inputs, let one edge sample them, return #1 after the edge.
  task automatic drive_tick(input logic [1:0] s, input logic [3:0] c);
    state_in = s;
    count_in = c;
    @(posedge clock_div);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock_div);
    reset    = 1'b0;
    state_in = 2'd0;
    count_in = 4'd15;
    @(negedge clock_div);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clock_div);
    reset    = 1'b0;
    state_in = 2'd3;
    count_in = 4'd7;
    @(posedge clock_div);
    #1;
    tests_run++;
    if ({red, yellow, green} !== 3'b100) begin
      tests_failed++;
      $display("FAIL reset_lamps got %b want 100", {red, yellow, green});
    end
    tests_run++;
    if ({seg_tens, seg_ones} !== 14'h3FFF) begin
      tests_failed++;
      $display("FAIL reset_digits got %h/%h want 7f/7f", seg_tens, seg_ones);
    end
    tests_run++;
    if (fault !== 1'b0 || cycles !== 8'd0) begin
      tests_failed++;
      $display("FAIL reset_fault_cycles got %b/%0d want 0/0", fault, cycles);
    end
    @(negedge clock_div);
    reset = 1'b1;
  endtask

  task automatic test_free_run();
    logic [1:0] s;
    logic [3:0] c;
    logic [2:0] exp_lamps;
    logic [6:0] exp_t, exp_o;
    do_reset();
    for (int k = 0; k < 66; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
      exp_lamps = (s == 2'd0) ? 3'b001 : (s == 2'd1) ? 3'b010 : 3'b100;
      exp_t = (c >= 10) ? 7'h79 : 7'h7F;
      exp_o = exp_digit((c >= 10) ? int'(c) - 10 : int'(c));
      tests_run++;
      if ({red, yellow, green} !== exp_lamps || seg_tens !== exp_t ||
          seg_ones !== exp_o || fault !== 1'b0) begin
        tests_failed++;
        $display("FAIL free_run tick %0d got rgy=%b%b%b %h/%h f=%b want %b %h/%h f=0",
                 k, red, yellow, green, seg_tens, seg_ones, fault, exp_lamps, exp_t, exp_o);
      end
    end
    tests_run++;
    if (cycles !== 8'd2 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL free_run_cycles got %0d f=%b want 2 f=0", cycles, fault);
    end
  endtask

  task automatic test_digits();
    do_reset();
    for (int c = 15; c >= 12; c--) drive_tick(2'd0, 4'(c));
    tests_run++;
    if (seg_tens !== 7'h79 || seg_ones !== 7'h24) begin
      tests_failed++;
      $display("FAIL digits_12 got %h/%h want 79/24", seg_tens, seg_ones);
    end
    for (int c = 11; c >= 9; c--) drive_tick(2'd0, 4'(c));
    tests_run++;
    if (seg_tens !== 7'h7F || seg_ones !== 7'h10) begin
      tests_failed++;
      $display("FAIL digits_9 got %h/%h want 7f/10", seg_tens, seg_ones);
    end
  endtask

  task automatic test_illegal_state();
    logic [1:0] s;
    logic [3:0] c;
    do_reset();
    for (int k = 0; k < 7; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    drive_tick(2'd3, 4'd8);
    tests_run++;
    if (fault !== 1'b1 || {red, yellow, green} !== 3'b010 ||
        seg_tens !== 7'h3F || seg_ones !== 7'h3F) begin
      tests_failed++;
      $display("FAIL illegal_entry got f=%b rgy=%b%b%b %h/%h want f=1 010 3f/3f",
               fault, red, yellow, green, seg_tens, seg_ones);
    end
    for (int j = 1; j <= 8; j++) begin
      if (j < 4) phase_at(7 + j, s, c);
      else begin s = 2'($urandom_range(0, 3)); c = 4'($urandom_range(0, 15)); end
      drive_tick(s, c);
      tests_run++;
      if (fault !== 1'b1 || yellow !== ((j % 2) == 0) || red !== 1'b0 || green !== 1'b0 ||
          seg_tens !== 7'h3F || seg_ones !== 7'h3F || cycles !== 8'd0) begin
        tests_failed++;
        $display("FAIL illegal_hold tick %0d got f=%b rgy=%b%b%b %h/%h c=%0d want y=%0d",
                 j, fault, red, yellow, green, seg_tens, seg_ones, cycles, (j % 2) == 0);
      end
    end
  endtask

  task automatic test_skip_count();
    logic [1:0] s;
    logic [3:0] c;
    do_reset();
    for (int k = 0; k < 33; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    tests_run++;
    if (cycles !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_precycle got %0d want 1", cycles);
    end
    drive_tick(2'd0, 4'd15);
    drive_tick(2'd0, 4'd14);
    tests_run++;
    if (fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL skip_before got f=%b want 0", fault);
    end
    drive_tick(2'd0, 4'd12);
    tests_run++;
    if (fault !== 1'b1 || cycles !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_edge got f=%b c=%0d want f=1 c=1", fault, cycles);
    end
    for (int k = 4; k < 40; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    tests_run++;
    if (fault !== 1'b1 || cycles !== 8'd1) begin
      tests_failed++;
      $display("FAIL skip_frozen got f=%b c=%0d want f=1 c=1", fault, cycles);
    end
  endtask

  task automatic test_reset_mid_yellow();
    logic [1:0] s;
    logic [3:0] c;
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    tests_run++;
    if (yellow !== 1'b1 || seg_ones !== 7'h30) begin
      tests_failed++;
      $display("FAIL mid_yellow_pre got y=%b ones=%h want 1/30", yellow, seg_ones);
    end
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({red, yellow, green} !== 3'b100 || seg_tens !== 7'h7F || seg_ones !== 7'h7F ||
        fault !== 1'b0 || cycles !== 8'd0) begin
      tests_failed++;
      $display("FAIL async_reset got rgy=%b%b%b %h/%h f=%b c=%0d want 100 7f/7f 0 0",
               red, yellow, green, seg_tens, seg_ones, fault, cycles);
    end
    @(negedge clock_div);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
      tests_run++;
      if ({red, yellow, green} !== 3'b001 || fault !== 1'b0 ||
          seg_ones !== exp_digit(int'(c) - 10)) begin
        tests_failed++;
        $display("FAIL restart tick %0d got rgy=%b%b%b f=%b ones=%h", k,
                 red, yellow, green, fault, seg_ones);
      end
    end
  endtask

  task automatic test_saturate();
    logic [1:0] s;
    logic [3:0] c;
    do_reset();
    for (int k = 0; k < 255 * 33; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    tests_run++;
    if (cycles !== 8'd255 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_reach got c=%0d f=%b want 255 f=0", cycles, fault);
    end
    for (int k = 0; k < 33; k++) begin
      phase_at(k, s, c);
      drive_tick(s, c);
    end
    tests_run++;
    if (cycles !== 8'd255 || fault !== 1'b0) begin
      tests_failed++;
      $display("FAIL sat_hold got c=%0d f=%b want 255 f=0", cycles, fault);
    end
  endtask

  initial begin
    reset    = 1'b1;
    state_in = 2'd0;
    count_in = 4'd15;
    test_reset();
    test_free_run();
    test_digits();
    test_illegal_state();
    test_skip_count();
    test_reset_mid_yellow();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
